bp_stat_ctrl: RTL and testbench
===============================

Name: bp_stat_ctrl

Overview:
Measurement controller for branch-predictor evaluation runs on the pipelined core. It taps the core's flush (misprediction), EX-stage branch/jump strobe, and IF instruction word. It sequences a measurement window through warm-up, measure and done phases, and accumulates saturating branch, miss and cycle counts. The bench or a CSR layer reads the counts once the block reports done.

Parameters:
CNT_W, 32, width of all statistic counters
WARMUP_BR, 16, branches discarded before counting starts; 0 means no warm-up
HALT_INSN, 32'h0000_0073, IF instruction word that ends the measurement (ecall)
WINDOW_BR, 64, branches per snapshot window (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous assert, active-low
start_i  in  1  pulse; arms a new run (accepted in IDLE or DONE)
stop_i  in  1  pulse; forces the end of the run
br_instr_i  in  1  EX-stage branch/jump resolved this cycle
br_miss_i  in  1  front-end flush (misprediction) this cycle
instr_i  in  32  IF-stage instruction word
busy_o  out  1  high in WARMUP or MEASURE
done_o  out  1  high in DONE
br_cnt_o  out  CNT_W  branches counted during MEASURE
miss_cnt_o  out  CNT_W  mispredictions counted during MEASURE
cyc_cnt_o  out  CNT_W  cycles spent in MEASURE
window_miss_o  out  16  misses in the last completed window (optional feature)
window_vld_o  out  1  1-cycle pulse when window_miss_o updates (optional feature)

Behaviour:
- Reset (asynchronous, rst_ni=0): state IDLE; all counters, internal warm-up counter and window registers cleared; all outputs 0.
- States: IDLE, WARMUP, MEASURE, DONE. State and all outputs are registered.
- IDLE/DONE + start_i: clear br/miss/cyc counters and warm-up counter. Next state is WARMUP, or MEASURE when WARMUP_BR=0.
- WARMUP:
  - Each br_instr_i increments the warm-up counter. On the WARMUP_BR-th branch, move to MEASURE next cycle. That branch is not counted.
  - br_miss_i is ignored in WARMUP.
- MEASURE, per cycle:
  - cyc_cnt += 1.
  - br_cnt += br_instr_i.
  - miss_cnt += br_miss_i.
  - Both strobes in the same cycle are both counted.
  - Counters saturate at all-ones and never wrap.
- End condition, from WARMUP or MEASURE: stop_i, or (instr_i==HALT_INSN and br_miss_i==0). A flushed fetch never ends the run.
  - Transition to DONE next cycle.
  - Events in the ending cycle are still counted if the state is MEASURE.
- DONE: counters hold; done_o=1 until start_i.
- start_i while busy_o=1 is ignored. stop_i in IDLE/DONE is ignored.
- start_i and stop_i together: stop_i wins when busy; start_i wins when idle or done.
- Count outputs are valid and stable whenever done_o=1. While busy they track live values with 1-cycle latency.
- Reset mid-run: immediate return to IDLE, counts lost.

Optional Feature:
Macro: BP_STAT_WINDOW_EN.
- Defined:
  - In MEASURE, a window branch counter and a window miss counter (16-bit, saturating) run alongside the main counters.
  - When the window branch counter reaches WINDOW_BR, window_miss_o is loaded with that window's misses, including a miss in the same cycle. window_vld_o pulses 1 cycle later, and both window counters restart from 0.
  - A partial window at run end is discarded.
- Undefined: window logic is absent; window_miss_o and window_vld_o are tied to 0.

Test Plan:
- Reset then idle: rst_ni low for 3 cycles, no start -> busy_o=0, done_o=0, all counts 0.
- WARMUP_BR=16: start, 20 branches with 1 cycle each, 3 misses after warm-up, then HALT_INSN -> br_cnt=4, miss_cnt=3, done_o=1.
- Flushed halt: HALT_INSN with br_miss_i=1 -> run continues; the next unflushed HALT_INSN -> DONE.
- Saturation: CNT_W=4, 20 MEASURE cycles -> cyc_cnt=15 held.
- stop_i and start_i together while busy -> DONE. A later start_i alone -> counts cleared, WARMUP entered.
- With BP_STAT_WINDOW_EN, WINDOW_BR=64, WARMUP_BR=0: 128 branches, 5 misses in the first 64 and 9 in the second -> window_miss_o=5 then 9, two window_vld_o pulses.

Source files
------------

// File: rtl/bp_stat_ctrl.sv
// Branch-predictor measurement controller: warm-up / measure / done sequencing with saturating counts.
// Optional per-window miss snapshots enabled by defining BP_STAT_WINDOW_EN.
module bp_stat_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WARMUP_BR = 16,
  parameter logic [31:0] HALT_INSN = 32'h0000_0073,
  parameter int unsigned WINDOW_BR = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic [31:0]      instr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [15:0]      window_miss_o,
  output logic             window_vld_o
);

  localparam int unsigned WU_W    = (WARMUP_BR > 1) ? $clog2(WARMUP_BR + 1) : 1;
  localparam int unsigned WU_LAST = (WARMUP_BR > 0) ? WARMUP_BR - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_MEASURE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d, cyc_cnt_q, cyc_cnt_d;
  logic             end_c, clr_c, meas_c, wu_inc_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // A flushed fetch of the halt word is wrong-path and must not end the run.
  assign end_c = stop_i || ((instr_i == HALT_INSN) && !br_miss_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = (WARMUP_BR == 0) ? S_MEASURE : S_WARMUP;
      end
      S_WARMUP: begin
        if (end_c)                                       state_d = S_DONE;
        else if (br_instr_i && (wu_q == WU_W'(WU_LAST))) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (end_c) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr_c    = 1'b0;
    meas_c   = 1'b0;
    wu_inc_c = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    clr_c    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    meas_c   = (state_q == S_MEASURE);
    wu_inc_c = (state_q == S_WARMUP) && br_instr_i;
    busy_d   = (state_d == S_WARMUP) || (state_d == S_MEASURE);
    done_d   = (state_d == S_DONE);
  end

  always_comb begin
    wu_d       = clr_c ? '0 : (wu_inc_c ? wu_q + WU_W'(1) : wu_q);
    br_cnt_d   = clr_c ? '0 : sat_inc(br_cnt_q, meas_c && br_instr_i);
    miss_cnt_d = clr_c ? '0 : sat_inc(miss_cnt_q, meas_c && br_miss_i);
    cyc_cnt_d  = clr_c ? '0 : sat_inc(cyc_cnt_q, meas_c);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wu_q       <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
      cyc_cnt_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      wu_q       <= wu_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign cyc_cnt_o  = cyc_cnt_q;

  logic unused_win;
  assign unused_win = ^WINDOW_BR;

`ifdef BP_STAT_WINDOW_EN
  logic [15:0] win_br_q, win_br_d, win_miss_q, win_miss_d, win_miss_inc;
  logic [15:0] window_miss_q, window_miss_d;
  logic        window_vld_q, window_vld_d, win_done_c;

  // Window closes on its WINDOW_BR-th branch; that cycle's miss belongs to it.
  assign win_done_c   = meas_c && br_instr_i && (win_br_q == 16'(WINDOW_BR - 1));
  assign win_miss_inc = (meas_c && br_miss_i && (win_miss_q != 16'hFFFF)) ?
                        win_miss_q + 16'(1) : win_miss_q;

  always_comb begin
    win_br_d      = win_br_q;
    win_miss_d    = win_miss_q;
    window_miss_d = window_miss_q;
    window_vld_d  = 1'b0;
    if (clr_c) begin
      win_br_d   = '0;
      win_miss_d = '0;
    end else if (win_done_c) begin
      window_miss_d = win_miss_inc;
      window_vld_d  = 1'b1;
      win_br_d      = '0;
      win_miss_d    = '0;
    end else if (meas_c) begin
      win_br_d   = (br_instr_i && (win_br_q != 16'hFFFF)) ? win_br_q + 16'(1) : win_br_q;
      win_miss_d = win_miss_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_br_q      <= '0;
      win_miss_q    <= '0;
      window_miss_q <= '0;
      window_vld_q  <= 1'b0;
    end else begin
      win_br_q      <= win_br_d;
      win_miss_q    <= win_miss_d;
      window_miss_q <= window_miss_d;
      window_vld_q  <= window_vld_d;
    end
  end

  assign window_miss_o = window_miss_q;
  assign window_vld_o  = window_vld_q;
`else
  assign window_miss_o = '0;
  assign window_vld_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bp_stat_ctrl.sv
// Directed bench for bp_stat_ctrl: main instance (WARMUP_BR=16) and a small
// saturation/window instance (CNT_W=4, WARMUP_BR=0, WINDOW_BR=64).
module tb_bp_stat_ctrl;

  localparam logic [31:0] HALT = 32'h0000_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic        m_start = 0, m_stop = 0, m_br = 0, m_miss = 0;
  logic [31:0] m_instr = NOP;
  logic        m_busy, m_done, m_wvld;
  logic [31:0] m_br_cnt, m_miss_cnt, m_cyc_cnt;
  logic [15:0] m_wmiss;

  logic        s_start = 0, s_stop = 0, s_br = 0, s_miss = 0;
  logic [31:0] s_instr = NOP;
  logic        s_busy, s_done, s_wvld;
  logic [3:0]  s_br_cnt, s_miss_cnt, s_cyc_cnt;
  logic [15:0] s_wmiss;

  always #5 clk = ~clk;

  bp_stat_ctrl #(.CNT_W(32), .WARMUP_BR(16), .HALT_INSN(HALT), .WINDOW_BR(64)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .start_i(m_start), .stop_i(m_stop),
    .br_instr_i(m_br), .br_miss_i(m_miss), .instr_i(m_instr),
    .busy_o(m_busy), .done_o(m_done), .br_cnt_o(m_br_cnt), .miss_cnt_o(m_miss_cnt),
    .cyc_cnt_o(m_cyc_cnt), .window_miss_o(m_wmiss), .window_vld_o(m_wvld));

  bp_stat_ctrl #(.CNT_W(4), .WARMUP_BR(0), .HALT_INSN(HALT), .WINDOW_BR(64)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .stop_i(s_stop),
    .br_instr_i(s_br), .br_miss_i(s_miss), .instr_i(s_instr),
    .busy_o(s_busy), .done_o(s_done), .br_cnt_o(s_br_cnt), .miss_cnt_o(s_miss_cnt),
    .cyc_cnt_o(s_cyc_cnt), .window_miss_o(s_wmiss), .window_vld_o(s_wvld));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests++; if (m_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    tests++; if (m_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", m_done); end
    tests++; if ({m_br_cnt, m_miss_cnt, m_cyc_cnt} !== 96'd0) begin fails++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", m_br_cnt, m_miss_cnt, m_cyc_cnt); end
    tests++; if ({s_busy, s_done, s_cyc_cnt, s_wmiss, s_wvld} !== 23'd0) begin fails++;
      $display("FAIL reset_small: got busy %b done %b cyc %0d wmiss %0d wvld %b want all 0",
               s_busy, s_done, s_cyc_cnt, s_wmiss, s_wvld); end
  endtask

  task automatic test_warmup_measure();
    m_start = 1; step(); m_start = 0;
    tests++; if (m_busy !== 1'b1) begin fails++; $display("FAIL wu_busy: got %b want 1", m_busy); end
    for (int i = 0; i < 20; i++) begin
      m_br = 1'b1;
      m_miss = (i >= 17) || (i == 4);
      step();
      if (i == 15) begin
        tests++; if (m_br_cnt !== 32'd0 || m_miss_cnt !== 32'd0) begin fails++;
          $display("FAIL wu_discard: got br %0d miss %0d want 0 0", m_br_cnt, m_miss_cnt); end
      end
    end
    m_br = 0; m_miss = 0;
    m_instr = HALT; step(); m_instr = NOP;
    tests++; if (m_done !== 1'b1 || m_busy !== 1'b0) begin fails++;
      $display("FAIL wm_state: got done %b busy %b want 1 0", m_done, m_busy); end
    tests++; if (m_br_cnt !== 32'd4) begin fails++; $display("FAIL wm_br_cnt: got %0d want 4", m_br_cnt); end
    tests++; if (m_miss_cnt !== 32'd3) begin fails++; $display("FAIL wm_miss_cnt: got %0d want 3", m_miss_cnt); end
    tests++; if (m_cyc_cnt !== 32'd5) begin fails++; $display("FAIL wm_cyc_cnt: got %0d want 5", m_cyc_cnt); end
    m_br = 1; m_miss = 1; m_stop = 1; step(); m_br = 0; m_miss = 0; m_stop = 0; step();
    tests++; if (m_done !== 1'b1 || m_br_cnt !== 32'd4 || m_cyc_cnt !== 32'd5) begin fails++;
      $display("FAIL done_hold: got done %b br %0d cyc %0d want 1 4 5", m_done, m_br_cnt, m_cyc_cnt); end
  endtask

  task automatic test_flushed_halt();
    m_start = 1; step(); m_start = 0;
    m_br = 1; repeat (16) step(); m_br = 0;
    m_instr = HALT; m_miss = 1; step();
    tests++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin fails++;
      $display("FAIL flush_halt_cont: got busy %b done %b want 1 0", m_busy, m_done); end
    m_miss = 0; step(); m_instr = NOP;
    tests++; if (m_done !== 1'b1) begin fails++; $display("FAIL flush_halt_done: got %b want 1", m_done); end
    tests++; if (m_miss_cnt !== 32'd1 || m_cyc_cnt !== 32'd2 || m_br_cnt !== 32'd0) begin fails++;
      $display("FAIL flush_halt_cnt: got br %0d miss %0d cyc %0d want 0 1 2", m_br_cnt, m_miss_cnt, m_cyc_cnt); end
  endtask

  task automatic test_stop_start();
    m_start = 1; step(); m_start = 0;
    m_br = 1; repeat (18) step();
    m_stop = 1; m_start = 1; step(); m_stop = 0; m_start = 0; m_br = 0;
    tests++; if (m_done !== 1'b1 || m_busy !== 1'b0) begin fails++;
      $display("FAIL ss_done: got done %b busy %b want 1 0", m_done, m_busy); end
    tests++; if (m_br_cnt !== 32'd3 || m_cyc_cnt !== 32'd3) begin fails++;
      $display("FAIL ss_cnt: got br %0d cyc %0d want 3 3", m_br_cnt, m_cyc_cnt); end
    m_start = 1; step(); m_start = 0;
    tests++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin fails++;
      $display("FAIL restart_state: got busy %b done %b want 1 0", m_busy, m_done); end
    tests++; if ({m_br_cnt, m_miss_cnt, m_cyc_cnt} !== 96'd0) begin fails++;
      $display("FAIL restart_clear: got %0d/%0d/%0d want 0/0/0", m_br_cnt, m_miss_cnt, m_cyc_cnt); end
    m_start = 1; step(); m_start = 0; step();
    tests++; if (m_cyc_cnt !== 32'd0 || m_busy !== 1'b1) begin fails++;
      $display("FAIL busy_start_ignored: got busy %b cyc %0d want 1 0", m_busy, m_cyc_cnt); end
    m_stop = 1; step(); m_stop = 0;
    tests++; if (m_done !== 1'b1 || m_cyc_cnt !== 32'd0) begin fails++;
      $display("FAIL wu_stop: got done %b cyc %0d want 1 0", m_done, m_cyc_cnt); end
  endtask

  task automatic test_saturation();
    s_start = 1; step(); s_start = 0;
    tests++; if (s_busy !== 1'b1 || s_cyc_cnt !== 4'd0) begin fails++;
      $display("FAIL sat_start: got busy %b cyc %0d want 1 0", s_busy, s_cyc_cnt); end
    s_br = 1; repeat (20) step(); s_br = 0;
    tests++; if (s_cyc_cnt !== 4'd15 || s_br_cnt !== 4'd15) begin fails++;
      $display("FAIL sat_cnt: got cyc %0d br %0d want 15 15", s_cyc_cnt, s_br_cnt); end
    s_stop = 1; step(); s_stop = 0; step();
    tests++; if (s_done !== 1'b1 || s_cyc_cnt !== 4'd15) begin fails++;
      $display("FAIL sat_hold: got done %b cyc %0d want 1 15", s_done, s_cyc_cnt); end
  endtask

  task automatic test_window();
    int pulses = 0;
    logic [15:0] w0 = 16'd0, w1 = 16'd0;
    int at0 = -1, at1 = -1;
`ifdef BP_STAT_WINDOW_EN
    localparam int EXP_P = 2;
    localparam logic [15:0] EXP_W0 = 16'd5, EXP_W1 = 16'd9;
    localparam int EXP_AT0 = 63, EXP_AT1 = 127;
`else
    localparam int EXP_P = 0;
    localparam logic [15:0] EXP_W0 = 16'd0, EXP_W1 = 16'd0;
    localparam int EXP_AT0 = -1, EXP_AT1 = -1;
`endif
    s_start = 1; step(); s_start = 0;
    for (int i = 0; i < 138; i++) begin
      s_br = 1'b1;
      s_miss = (i >= 59 && i <= 72) || (i >= 128);
      step();
      if (s_wvld === 1'b1) begin
        if (pulses == 0) begin w0 = s_wmiss; at0 = i; end
        else if (pulses == 1) begin w1 = s_wmiss; at1 = i; end
        pulses++;
      end
    end
    s_br = 0; s_miss = 0;
    s_stop = 1; step(); s_stop = 0; step();
    tests++; if (pulses != EXP_P) begin fails++; $display("FAIL win_pulses: got %0d want %0d", pulses, EXP_P); end
    tests++; if (w0 !== EXP_W0 || at0 != EXP_AT0) begin fails++;
      $display("FAIL win_first: got %0d at %0d want %0d at %0d", w0, at0, EXP_W0, EXP_AT0); end
    tests++; if (w1 !== EXP_W1 || at1 != EXP_AT1) begin fails++;
      $display("FAIL win_second: got %0d at %0d want %0d at %0d", w1, at1, EXP_W1, EXP_AT1); end
    tests++; if (s_wmiss !== EXP_W1 || s_wvld !== 1'b0) begin fails++;
      $display("FAIL win_partial: got %0d vld %b want %0d 0", s_wmiss, s_wvld, EXP_W1); end
  endtask

  task automatic test_reset_midrun();
    m_start = 1; step(); m_start = 0;
    m_br = 1; repeat (19) step(); m_br = 0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (m_busy !== 1'b0 || m_done !== 1'b0 || m_cyc_cnt !== 32'd0 || m_br_cnt !== 32'd0) begin fails++;
      $display("FAIL async_reset: got busy %b done %b br %0d cyc %0d want 0 0 0 0",
               m_busy, m_done, m_br_cnt, m_cyc_cnt); end
    step(); rst_n = 1'b1; step();
    tests++; if (m_busy !== 1'b0 || m_done !== 1'b0) begin fails++;
      $display("FAIL post_reset_idle: got busy %b done %b want 0 0", m_busy, m_done); end
  endtask

  initial begin
    test_reset();
    test_warmup_measure();
    test_flushed_halt();
    test_stop_start();
    test_saturation();
    test_window();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
